// File: rtl/block_nest_checker.sv
// block_nest_checker
// Streaming keyword-nesting checker. Tokenises an ASCII character stream into
// words and tracks begin/end (and optionally parenthesis) nesting on a typed
// stack. It reports a running balanced verdict, a sticky error and the
// committed stack depth.
module block_nest_checker #(
  parameter int DEPTH     = 16,
  parameter bit PAREN_EN  = 1'b1,
  parameter bit CASE_SENS = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   in,
  input  logic                         in_valid,
  output logic                         result,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(DEPTH + 1);
  // Stack storage is sized to the full depth-counter range so the counter can
  // index it directly; only the lower DEPTH entries are ever pushed.
  localparam int SW = 1 << DW;

  localparam logic TYPE_BEG = 1'b0;
  localparam logic TYPE_PAR = 1'b1;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_OPEN  = 8'h28;
  localparam logic [7:0] CH_CLOSE = 8'h29;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_D     = 8'h64;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_NIL = DW'(0);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_B     = 4'd1,
    ST_BE    = 4'd2,
    ST_BEG   = 4'd3,
    ST_BEGI  = 4'd4,
    ST_BEGIN = 4'd5,
    ST_E     = 4'd6,
    ST_EN    = 4'd7,
    ST_END   = 4'd8,
    ST_OTHER = 4'd9
  } state_t;

  // Registered state
  state_t          state_r;
  logic [DW-1:0]   depth_r;
  logic [SW-1:0]   stack_r;
  logic            err_r;
  logic            result_r;

  // Combinational next-state signals
  logic [7:0]      letter_s;
  logic            is_open_s;
  logic            is_close_s;
  logic            is_delim_s;
  state_t          state_nxt_s;

  logic [DW-1:0]   depth_c_s;   // after keyword commit
  logic [SW-1:0]   stack_c_s;
  logic            err_c_s;
  logic [DW-1:0]   depth_p_s;   // after parenthesis token
  logic [SW-1:0]   stack_p_s;
  logic            err_p_s;

  logic [DW-1:0]   depth_nxt_s;
  logic [SW-1:0]   stack_nxt_s;
  logic            err_nxt_s;
  logic            result_nxt_s;

  // Balanced verdict for a given register image, treating the pending word as complete
  function automatic logic calc_result(
    input state_t        st,
    input logic [DW-1:0] d,
    input logic [SW-1:0] stk,
    input logic          e
  );
    logic top_beg;
    logic r;
    top_beg = (stk[d - DEPTH_ONE] == TYPE_BEG);
    if (e) begin
      r = 1'b0;
    end else if (st == ST_BEGIN) begin
      r = 1'b0;
    end else if (st == ST_END) begin
      r = (d == DEPTH_ONE) && top_beg;
    end else begin
      r = (d == DEPTH_NIL);
    end
    return r;
  endfunction

  // Character classification and optional case folding
  always_comb begin
    is_open_s  = PAREN_EN && (in == CH_OPEN);
    is_close_s = PAREN_EN && (in == CH_CLOSE);
    is_delim_s = (in == CH_SPACE) || is_open_s || is_close_s;
    if (!CASE_SENS && (in >= 8'h41) && (in <= 8'h5A)) begin
      letter_s = in | 8'h20;
    end else begin
      letter_s = in;
    end
  end

  // Word matcher next state: keyword states advance only on the expected letter
  always_comb begin
    state_nxt_s = state_r;
    if (is_delim_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (letter_s == CH_B) begin
            state_nxt_s = ST_B;
          end else if (letter_s == CH_E) begin
            state_nxt_s = ST_E;
          end else begin
            state_nxt_s = ST_OTHER;
          end
        end
        ST_B:    state_nxt_s = (letter_s == CH_E) ? ST_BE    : ST_OTHER;
        ST_BE:   state_nxt_s = (letter_s == CH_G) ? ST_BEG   : ST_OTHER;
        ST_BEG:  state_nxt_s = (letter_s == CH_I) ? ST_BEGI  : ST_OTHER;
        ST_BEGI: state_nxt_s = (letter_s == CH_N) ? ST_BEGIN : ST_OTHER;
        ST_E:    state_nxt_s = (letter_s == CH_N) ? ST_EN    : ST_OTHER;
        ST_EN:   state_nxt_s = (letter_s == CH_D) ? ST_END   : ST_OTHER;
        default: state_nxt_s = ST_OTHER;
      endcase
    end
  end

  // Keyword commit on a delimiter: BEGIN pushes BEG, END pops a BEG
  always_comb begin
    depth_c_s = depth_r;
    stack_c_s = stack_r;
    err_c_s   = 1'b0;
    if (is_delim_s && (state_r == ST_BEGIN)) begin
      if (depth_r == DEPTH_MAX) begin
        err_c_s = 1'b1;
      end else begin
        stack_c_s[depth_r] = TYPE_BEG;
        depth_c_s          = depth_r + DEPTH_ONE;
      end
    end else if (is_delim_s && (state_r == ST_END)) begin
      if ((depth_r == DEPTH_NIL) || (stack_r[depth_r - DEPTH_ONE] != TYPE_BEG)) begin
        err_c_s = 1'b1;
      end else begin
        depth_c_s = depth_r - DEPTH_ONE;
      end
    end else begin
      err_c_s = 1'b0;
    end
  end

  // Parenthesis token applied on top of the commit result; an earlier error stops it
  always_comb begin
    depth_p_s = depth_c_s;
    stack_p_s = stack_c_s;
    err_p_s   = err_c_s;
    if (!err_c_s && is_open_s) begin
      if (depth_c_s == DEPTH_MAX) begin
        err_p_s = 1'b1;
      end else begin
        stack_p_s[depth_c_s] = TYPE_PAR;
        depth_p_s            = depth_c_s + DEPTH_ONE;
      end
    end else if (!err_c_s && is_close_s) begin
      if ((depth_c_s == DEPTH_NIL) || (stack_c_s[depth_c_s - DEPTH_ONE] != TYPE_PAR)) begin
        err_p_s = 1'b1;
      end else begin
        depth_p_s = depth_c_s - DEPTH_ONE;
      end
    end else begin
      err_p_s = err_c_s;
    end
  end

  // Freeze the stack once the sticky error is set and derive the next verdict
  always_comb begin
    if (err_r) begin
      depth_nxt_s = depth_r;
      stack_nxt_s = stack_r;
      err_nxt_s   = 1'b1;
    end else begin
      depth_nxt_s = depth_p_s;
      stack_nxt_s = stack_p_s;
      err_nxt_s   = err_p_s;
    end
    result_nxt_s = calc_result(state_nxt_s, depth_nxt_s, stack_nxt_s, err_nxt_s);
  end

  // State registers: synchronous reset, otherwise update only on accepted characters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      depth_r  <= DEPTH_NIL;
      stack_r  <= {SW{1'b0}};
      err_r    <= 1'b0;
      result_r <= 1'b1;
    end else if (in_valid) begin
      state_r  <= state_nxt_s;
      depth_r  <= depth_nxt_s;
      stack_r  <= stack_nxt_s;
      err_r    <= err_nxt_s;
      result_r <= result_nxt_s;
    end
  end

  assign result = result_r;
  assign err    = err_r;
  assign depth  = depth_r;

endmodule
